// File: rtl/pe_dw_pkg.sv
// +--------------------------------------------------------------------------+
// | pe_dw_pkg : shared types, default sizes and requantisation helper        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package pe_dw_pkg;

   localparam int NUM_CH_DEF      = 4;
   localparam int DATA_W_DEF      = 8;
   localparam int ACC_W_DEF       = 24;
   localparam int KERNEL_TAPS_DEF = 9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   // Round-half-up arithmetic shift, then clamp to a signed dw-bit range.
   function automatic logic signed [63:0] requant_sat(
      input logic signed [63:0] acc,
      input logic        [4:0]  shift,
      input int unsigned        dw
   );
      logic signed [63:0] r;
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      max_v = (64'sd1 <<< (dw - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (dw - 1));
      r     = acc + ((shift != 5'd0) ? (64'sd1 <<< (shift - 5'd1)) : 64'sd0);
      r     = r >>> shift;
      if (r > max_v)
         r = max_v;
      else if (r < min_v)
         r = min_v;
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pe_dw_mac_lane.sv
// +--------------------------------------------------------------------------+
// | pe_dw_mac_lane : one channel MAC with requantised output register        |
// | Optional macro PE_DW_CLUSTER_RELU_EN clamps negative results to zero.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module pe_dw_mac_lane
   import pe_dw_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     en,
   input  logic                     beat,
   input  logic                     load,
   input  logic        [4:0]        shift,
   input  logic signed [DATA_W-1:0] ifm,
   input  logic signed [DATA_W-1:0] weight,
   output logic signed [DATA_W-1:0] ofm
);

   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    acc;
   logic signed [ACC_W-1:0]    acc_next;
   logic signed [DATA_W-1:0]   sat;
   logic signed [DATA_W-1:0]   res;

   assign prod     = ifm * weight;
   // The final beat's product is folded in here so the result loads on the same edge.
   assign acc_next = acc + ((beat && en) ? ACC_W'(prod) : '0);
   assign sat      = DATA_W'(requant_sat(64'(acc_next), shift, DATA_W));

   always_comb begin
      res = sat;
`ifdef PE_DW_CLUSTER_RELU_EN
      if (sat[DATA_W-1])
         res = '0;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
         ofm <= '0;
      end else begin
         if (clear)
            acc <= '0;
         else if (beat && en)
            acc <= acc_next;
         if (load)
            ofm <= en ? res : '0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/pe_dw_cluster_param.sv
// +--------------------------------------------------------------------------+
// | pe_dw_cluster_param : depthwise-conv PE cluster, FSM and handshakes      |
// | Optional macro PE_DW_CLUSTER_RELU_EN (applied inside each lane).         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module pe_dw_cluster_param
   import pe_dw_pkg::*;
#(
   parameter int NUM_CH      = NUM_CH_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int ACC_W       = ACC_W_DEF,
   parameter int KERNEL_TAPS = KERNEL_TAPS_DEF
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic [NUM_CH-1:0]        ch_en,
   input  logic [4:0]               cfg_shift,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NUM_CH*DATA_W-1:0] ifm,
   input  logic [NUM_CH*DATA_W-1:0] weight,
   output logic [NUM_CH*DATA_W-1:0] ofm,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NUM_CH-1:0]        lane_valid,
   output logic                     busy
);

   localparam int TAP_W = (KERNEL_TAPS > 1) ? $clog2(KERNEL_TAPS) : 1;

   state_t            state;
   logic [TAP_W-1:0]  tap_cnt;
   logic [NUM_CH-1:0] en_l;
   logic [4:0]        shift_l;

   logic handshake;
   logic last_tap;
   logic clear;
   logic beat;
   logic load;

   assign handshake = out_valid && out_ready;
   assign last_tap  = (tap_cnt == TAP_W'(KERNEL_TAPS - 1));
   // A start in ACCUM aborts the window, so a coincident beat never reaches the lanes.
   assign clear     = start && ((state == IDLE) || (state == ACCUM) ||
                                ((state == HOLD) && handshake));
   assign beat      = in_valid && in_ready && !start;
   assign load      = beat && last_tap;

   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         state      <= IDLE;
         tap_cnt    <= '0;
         en_l       <= '0;
         shift_l    <= '0;
         in_ready   <= 1'b0;
         out_valid  <= 1'b0;
         lane_valid <= '0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= ACCUM;
                  tap_cnt  <= '0;
                  en_l     <= ch_en;
                  shift_l  <= cfg_shift;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            ACCUM: begin
               if (start) begin
                  tap_cnt <= '0;
                  en_l    <= ch_en;
                  shift_l <= cfg_shift;
               end else if (beat) begin
                  if (last_tap) begin
                     state      <= HOLD;
                     tap_cnt    <= '0;
                     in_ready   <= 1'b0;
                     out_valid  <= 1'b1;
                     lane_valid <= en_l;
                  end else begin
                     tap_cnt <= tap_cnt + TAP_W'(1);
                  end
               end
            end
            HOLD: begin
               if (handshake) begin
                  out_valid  <= 1'b0;
                  lane_valid <= '0;
                  if (start) begin
                     state    <= ACCUM;
                     tap_cnt  <= '0;
                     en_l     <= ch_en;
                     shift_l  <= cfg_shift;
                     in_ready <= 1'b1;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
      pe_dw_mac_lane #(
         .DATA_W (DATA_W),
         .ACC_W  (ACC_W)
      ) u_lane (
         .clk    (clk),
         .rst    (reset_n),
         .clear  (clear),
         .en     (en_l[c]),
         .beat   (beat),
         .load   (load),
         .shift  (shift_l),
         .ifm    (ifm[c*DATA_W +: DATA_W]),
         .weight (weight[c*DATA_W +: DATA_W]),
         .ofm    (ofm[c*DATA_W +: DATA_W])
      );
   end

endmodule

`default_nettype wire

// File: tb/tb_pe_dw_cluster_param.sv
// +--------------------------------------------------------------------------+
// | tb_pe_dw_cluster_param : directed + randomized bench with window model   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pe_dw_cluster_param;

   localparam int NC = 4;
   localparam int DW = 8;
   localparam int K  = 9;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic [NC-1:0] ch_en;
   logic [4:0]    cfg_shift;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   ifm;
   logic [31:0]   weight;
   logic [31:0]   ofm;
   logic          out_valid;
   logic          out_ready;
   logic [NC-1:0] lane_valid;
   logic          busy;

   int total  = 0;
   int passed = 0;
   int failed = 0;

   int          sum_m [NC];
   logic [3:0]  en_m;
   int          shift_m;
   logic [31:0] snap;

   always #5 clk = ~clk;

   pe_dw_cluster_param #(
      .NUM_CH(NC), .DATA_W(DW), .ACC_W(24), .KERNEL_TAPS(K)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .ch_en(ch_en),
      .cfg_shift(cfg_shift), .in_valid(in_valid), .in_ready(in_ready),
      .ifm(ifm), .weight(weight), .ofm(ofm), .out_valid(out_valid),
      .out_ready(out_ready), .lane_valid(lane_valid), .busy(busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total = total + 1;
      assert (got === exp) passed = passed + 1;
      else begin
         failed = failed + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Window result from the plain sum, round-half-up divide by 2^shift, clamp.
   function automatic logic [7:0] exp_lane(input int c);
      longint v;
      if (!en_m[c]) return 8'h00;
      v = longint'(sum_m[c]);
      if (shift_m > 0) v = v + (longint'(1) << (shift_m - 1));
      v = v >>> shift_m;
      if (v > 127)  v = 127;
      if (v < -128) v = -128;
`ifdef PE_DW_CLUSTER_RELU_EN
      if (v < 0) v = 0;
`endif
      return v[7:0];
   endfunction

   function automatic logic [31:0] exp_ofm();
      logic [31:0] r;
      for (int c = 0; c < NC; c++) r[c*8 +: 8] = exp_lane(c);
      return r;
   endfunction

   task automatic model_start(input logic [3:0] en, input int sh);
      for (int c = 0; c < NC; c++) sum_m[c] = 0;
      en_m    = en;
      shift_m = sh;
   endtask

   task automatic do_start(input logic [3:0] en, input int sh);
      start = 1'b1; ch_en = en; cfg_shift = sh[4:0];
      @(posedge clk); #1;
      start = 1'b0;
      model_start(en, sh);
   endtask

   task automatic beat(input logic [31:0] f, input logic [31:0] w);
      logic [7:0] fb, wb;
      ifm = f; weight = w; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int c = 0; c < NC; c++) begin
         fb = f[c*8 +: 8];
         wb = w[c*8 +: 8];
         if (en_m[c]) sum_m[c] = sum_m[c] + int'($signed(fb)) * int'($signed(wb));
      end
   endtask

   task automatic run_rand(input int n, input bit gaps);
      for (int i = 0; i < n; i++) begin
         if (gaps && ($urandom_range(0, 3) == 0)) begin
            ifm = $urandom(); in_valid = 1'b0;
            @(posedge clk); #1;
         end
         beat($urandom(), $urandom());
      end
   endtask

   task automatic check_result(input string tag);
      check({tag, "_ov"}, 64'(out_valid), 64'd1);
      check({tag, "_lv"}, 64'(lane_valid), 64'(en_m));
      check({tag, "_ofm"}, 64'(ofm), 64'(exp_ofm()));
      check({tag, "_ir"}, 64'(in_ready), 64'd0);
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_hs_ov"}, 64'(out_valid), 64'd0);
      check({tag, "_hs_busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      reset_n = 1'b1; start = 1'b0; ch_en = '0; cfg_shift = '0;
      in_valid = 1'b0; out_ready = 1'b0; ifm = '0; weight = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ov", 64'(out_valid), 64'd0);
      check("rst_ir", 64'(in_ready), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_ofm", 64'(ofm), 64'd0);
      check("rst_lv", 64'(lane_valid), 64'd0);
      reset_n = 1'b0;
      @(posedge clk); #1;

      // Basic window: 2*3 summed over 9 taps
      do_start(4'hF, 0);
      check("t1_busy", 64'(busy), 64'd1);
      check("t1_ir", 64'(in_ready), 64'd1);
      for (int i = 0; i < K - 1; i++) beat({4{8'd2}}, {4{8'd3}});
      check("t1_early", 64'(out_valid), 64'd0);
      beat({4{8'd2}}, {4{8'd3}});
      check_result("t1");
      check("t1_const", 64'(ofm), 64'({4{8'd54}}));
      handshake("t1");

      // Saturation: lane0 127*127, lane1 -128*127, lane2 1*1, lane3 -1*1
      do_start(4'hF, 4);
      for (int i = 0; i < K; i++) beat({8'hFF, 8'h01, 8'h80, 8'h7F}, {8'h01, 8'h01, 8'h7F, 8'h7F});
      check_result("t2");
      check("t2_l0", 64'(ofm[7:0]), 64'h7F);
`ifdef PE_DW_CLUSTER_RELU_EN
      check("t2_l1", 64'(ofm[15:8]), 64'h00);
`else
      check("t2_l1", 64'(ofm[15:8]), 64'h80);
`endif
      handshake("t2");

      // Rounding: totals 6, -6, 7, -7 with shift 2
      do_start(4'hF, 2);
      beat({8'hF9, 8'h07, 8'hFE, 8'h02}, {8'h01, 8'h01, 8'h03, 8'h03});
      for (int i = 0; i < K - 1; i++) beat(32'h0, 32'h0);
      check_result("t3");
`ifdef PE_DW_CLUSTER_RELU_EN
      check("t3_const", 64'(ofm), 64'h00020002);
`else
      check("t3_const", 64'(ofm), 64'hFE02FF02);
`endif
      handshake("t3");

      // Backpressure, ignored beats/start in HOLD, then back-to-back window
      do_start(4'hF, 5);
      run_rand(K, 1'b1);
      check_result("t4");
      snap = exp_ofm();
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; ifm = $urandom(); weight = $urandom();
         start = (i == 2); ch_en = 4'h0; cfg_shift = 5'd1;
         @(posedge clk); #1;
         check("t4_stable", 64'(ofm), 64'(snap));
         check("t4_hold_ir", 64'(in_ready), 64'd0);
         check("t4_hold_ov", 64'(out_valid), 64'd1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1; start = 1'b1; ch_en = 4'hA; cfg_shift = 5'd3;
      @(posedge clk); #1;
      out_ready = 1'b0; start = 1'b0;
      model_start(4'hA, 3);
      check("t4_b2b_ov", 64'(out_valid), 64'd0);
      check("t4_b2b_ir", 64'(in_ready), 64'd1);
      check("t4_b2b_busy", 64'(busy), 64'd1);
      run_rand(K, 1'b0);
      check_result("t4b");
      handshake("t4b");

      // Abort after 4 beats; beat offered with the restart is discarded
      do_start(4'hF, 1);
      run_rand(4, 1'b0);
      start = 1'b1; ch_en = 4'hF; cfg_shift = 5'd2;
      in_valid = 1'b1; ifm = $urandom(); weight = $urandom();
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b0;
      model_start(4'hF, 2);
      run_rand(K, 1'b1);
      check_result("t5");
      handshake("t5");

      // Partial lane enable
      do_start(4'b0101, 3);
      run_rand(K, 1'b1);
      check_result("t6");
      check("t6_dis", 64'({ofm[31:24], ofm[15:8]}), 64'h0);
      handshake("t6");

      // Random windows with random stalls
      for (int w = 0; w < 8; w++) begin
         do_start(4'($urandom_range(0, 15)), $urandom_range(0, 20));
         run_rand(K, 1'b1);
         check_result("t7");
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         handshake("t7");
      end

      // Reset mid-window
      do_start(4'hF, 0);
      run_rand(K, 1'b0);
      handshake("t8pre");
      do_start(4'hF, 0);
      run_rand(5, 1'b0);
      #2;
      reset_n = 1'b1;
      #1;
      check("t8_ov", 64'(out_valid), 64'd0);
      check("t8_busy", 64'(busy), 64'd0);
      check("t8_ir", 64'(in_ready), 64'd0);
      check("t8_ofm", 64'(ofm), 64'd0);
      check("t8_lv", 64'(lane_valid), 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b0;
      @(posedge clk); #1;

      // Clean window after reset
      do_start(4'hF, 0);
      run_rand(K, 1'b0);
      check_result("t9");
      handshake("t9");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
